// File: rtl/muldiv_pkg.sv
// Shared opcodes and FSM state encoding for the MULT/DIV/MFHI/MFLO sequencer.
package muldiv_pkg;

  localparam logic [5:0] OpMult = 6'b000010;
  localparam logic [5:0] OpDiv  = 6'b000011;
  localparam logic [5:0] OpMfhi = 6'b000100;
  localparam logic [5:0] OpMflo = 6'b000101;
  localparam logic [5:0] OpNop  = 6'b100001;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StDz,
    StFix
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, acc_i} + (quo_i[0] ? {1'b0, b_i} : '0);
    shifted = {acc_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, b_i};
    if (is_div_i) begin
      // Borrow out of the trial subtract means the divisor did not fit: restore.
      if (trial[WIDTH]) begin
        acc_o = shifted[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = trial[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = sum[WIDTH:1];
      quo_o = {sum[0], quo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/DIV controller owning HI/LO; stalls decode on HI/LO hazards.
// Define MULDIV_SIGNED_EN for signed MULT/DIV (adds the FIX cycle).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             x_valid,
  input  logic [5:0]       x_aluop,
  input  logic [WIDTH-1:0] x_rs,
  input  logic [WIDTH-1:0] x_rt,
  input  logic [5:0]       d_aluop,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div_zero_q, div_zero_d;
  logic             x_start, last_iter;
  logic [WIDTH-1:0] step_acc, step_quo, rs_mag, rt_mag;

`ifdef MULDIV_SIGNED_EN
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, op_div_q, op_div_d;
  logic [2*WIDTH-1:0] prod;

  assign rs_mag = x_rs[WIDTH-1] ? -x_rs : x_rs;
  assign rt_mag = x_rt[WIDTH-1] ? -x_rt : x_rt;
  assign prod   = {acc_q, quo_q};
`else
  assign rs_mag = x_rs;
  assign rt_mag = x_rt;
`endif

  assign busy      = (state_q != StIdle);
  assign x_start   = x_valid && (x_aluop == OpMult || x_aluop == OpDiv) && (state_q == StIdle);
  assign stall     = (d_aluop inside {OpMult, OpDiv, OpMfhi, OpMflo}) && (busy || x_start);
  assign last_iter = (count_q == CNT_W'(WIDTH - 1));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div_zero  = div_zero_q;

  always_comb begin
    case (x_aluop)
      OpMfhi:  mf_data = hi_q;
      OpMflo:  mf_data = lo_q;
      default: mf_data = '0;
    endcase
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i(state_q == StDiv),
    .acc_i   (acc_q),
    .quo_i   (quo_q),
    .b_i     (opb_q),
    .acc_o   (step_acc),
    .quo_o   (step_quo)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    quo_d      = quo_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    op_div_d   = op_div_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (x_start) begin
          count_d = '0;
          acc_d   = '0;
          quo_d   = rs_mag;
          opb_d   = rt_mag;
`ifdef MULDIV_SIGNED_EN
          neg_res_d = x_rs[WIDTH-1] ^ x_rt[WIDTH-1];
          neg_rem_d = x_rs[WIDTH-1];
          op_div_d  = (x_aluop == OpDiv);
`endif
          if (x_aluop == OpMult) begin
            state_d = StMul;
          end else if (x_rt == '0) begin
            // Raw dividend is what HI reports on divide-by-zero.
            quo_d   = x_rs;
            state_d = StDz;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StMul, StDiv: begin
        acc_d   = step_acc;
        quo_d   = step_quo;
        count_d = count_q + CNT_W'(1);
        if (last_iter) begin
          count_d = '0;
`ifdef MULDIV_SIGNED_EN
          state_d = StFix;
`else
          hi_d    = step_acc;
          lo_d    = step_quo;
          state_d = StIdle;
`endif
        end
      end
      StDz: begin
        hi_d       = quo_q;
        lo_d       = '1;
        div_zero_d = 1'b1;
        state_d    = StIdle;
      end
`ifdef MULDIV_SIGNED_EN
      StFix: begin
        if (op_div_q) begin
          lo_d = neg_res_q ? -quo_q : quo_q;
          hi_d = neg_rem_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? -prod : prod;
        end
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      acc_q      <= '0;
      quo_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      op_div_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      op_div_q   <= op_div_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: random and directed MULT/DIV against an arithmetic model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         x_valid = 1'b0;
  logic [5:0]   x_aluop = OpNop;
  logic [5:0]   d_aluop = OpNop;
  logic [W-1:0] x_rs = '0;
  logic [W-1:0] x_rt = '0;
  logic         stall, busy, div_zero;
  logic [W-1:0] hi, lo, mf_data;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cycles;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  muldiv_sequencer #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .x_valid (x_valid),
    .x_aluop (x_aluop),
    .x_rs    (x_rs),
    .x_rt    (x_rt),
    .d_aluop (d_aluop),
    .stall   (stall),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mf_data (mf_data),
    .div_zero(div_zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    logic [2*W-1:0] p;
    longint       sa, sb, q, r;
    e.dz     = 1'b0;
    e.cycles = W + Extra;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OpDiv && b == '0) begin
      e.hi     = a;
      e.lo     = '1;
      e.dz     = 1'b1;
      e.cycles = 1;
    end else if (op == OpMult) begin
`ifdef MULDIV_SIGNED_EN
      p = sa * sb;
`else
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else begin
`ifdef MULDIV_SIGNED_EN
      q = sa / sb;
      r = sa % sb;
`else
      q = longint'({32'b0, a}) / longint'({32'b0, b});
      r = longint'({32'b0, a}) % longint'({32'b0, b});
`endif
      e.lo = q[W-1:0];
      e.hi = r[W-1:0];
    end
    return e;
  endfunction

  // Monitor: a busy->idle transition is a commit; compare it with the oldest expectation.
  initial begin : monitor
    int   run;
    logic prev;
    logic dz_follow;
    exp_t e;
    run = 0;
    prev = 1'b0;
    dz_follow = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        run = 0;
        prev = 1'b0;
        dz_follow = 1'b0;
      end else begin
        if (dz_follow) begin
          check("div_zero_pulse_end", W'(div_zero), '0);
          dz_follow = 1'b0;
        end
        if (busy) begin
          run++;
        end else if (prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_commit", W'(1), '0);
          end else begin
            e = exp_q.pop_front();
            check("sb_hi", hi, e.hi);
            check("sb_lo", lo, e.lo);
            check("sb_div_zero", W'(div_zero), W'(e.dz));
            check("sb_busy_cycles", W'(run), W'(e.cycles));
            dz_follow = e.dz;
          end
          run = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    @(negedge clock);
    x_valid = 1'b1;
    x_aluop = op;
    x_rs    = a;
    x_rt    = b;
    if (push) exp_q.push_back(model(op, a, b));
    @(negedge clock);
    x_valid = 1'b0;
    x_aluop = OpNop;
    x_rs    = $urandom;
    x_rt    = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy) check({name, "_timeout"}, W'(busy), '0);
    @(negedge clock);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    logic [5:0] op;
    logic [W-1:0] a, b;

    repeat (2) @(negedge clock);
    d_aluop = OpMfhi;
    #1;
    check("reset_busy", W'(busy), '0);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_div_zero", W'(div_zero), '0);
    check("reset_stall", W'(stall), '0);
    d_aluop = OpNop;
    reset_n = 1'b1;

    issue(OpMult, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_idle("mult_16x16");
    check("mult_16x16_hi", hi, 32'h0000_0001);
    check("mult_16x16_lo", lo, 32'h0000_0000);

    issue(OpDiv, 32'd100, 32'd7, 1'b1);
    wait_idle("div_100_7");
    check("div_100_7_lo", lo, 32'd14);
    check("div_100_7_hi", hi, 32'd2);

    issue(OpDiv, 32'h1234, 32'h0, 1'b1);
    wait_idle("div_zero");
    check("div_zero_hi", hi, 32'h0000_1234);
    check("div_zero_lo", lo, 32'hFFFF_FFFF);

    // MULT in X with MFLO in D: F/D is held while stall is high.
    @(negedge clock);
    x_valid = 1'b1;
    x_aluop = OpMult;
    x_rs    = 32'd3;
    x_rt    = 32'd5;
    d_aluop = OpMflo;
    exp_q.push_back(model(OpMult, 32'd3, 32'd5));
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clock);
      x_valid = 1'b0;
      x_aluop = OpNop;
      #1;
    end
    check("stall_cycles", W'(n), W'(W + 1 + Extra));
    d_aluop = OpNop;
    x_valid = 1'b1;
    x_aluop = OpMflo;
    #1;
    check("mflo_data", mf_data, 32'd15);
    x_aluop = OpMfhi;
    #1;
    check("mfhi_data", mf_data, 32'd0);
    x_aluop = OpNop;
    x_valid = 1'b0;
    #1;
    check("mf_data_other", mf_data, 32'd0);

    // Only muldiv-group opcodes in D see the hazard.
    issue(OpMult, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
    d_aluop = 6'b100000;
    #1;
    check("stall_alu_in_d", W'(stall), '0);
    d_aluop = OpNop;
    #1;
    check("stall_nop_in_d", W'(stall), '0);
    d_aluop = OpDiv;
    #1;
    check("stall_div_in_d", W'(stall), W'(1));
    d_aluop = OpNop;
    wait_idle("alu_in_d");

    issue(OpMult, 32'hFFFF_FFFA, 32'd7, 1'b1);
    wait_idle("mult_neg6_7");
`ifdef MULDIV_SIGNED_EN
    check("mult_neg6_7_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg6_7_lo", lo, 32'hFFFF_FFD6);
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle("div_neg7_2");
    check("div_neg7_2_lo", lo, 32'hFFFF_FFFD);
    check("div_neg7_2_hi", hi, 32'hFFFF_FFFF);
`else
    check("mult_neg6_7_hi", hi, 32'h0000_0006);
    check("mult_neg6_7_lo", lo, 32'hFFFF_FFD6);
`endif

    // Reset mid-multiply discards the operation.
    issue(OpMult, 32'hCAFE_F00D, 32'h0BAD_C0DE, 1'b0);
    repeat (9) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_busy", W'(busy), '0);
    check("midreset_hi", hi, '0);
    check("midreset_lo", lo, '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    issue(OpDiv, 32'd9, 32'd3, 1'b1);
    wait_idle("div_9_3");
    check("div_9_3_lo", lo, 32'd3);
    check("div_9_3_hi", hi, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OpMult : OpDiv;
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = ~W'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 1000));
      issue(op, a, b, 1'b1);
      wait_idle("random");
    end

    check("scoreboard_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
